// File: rtl/rca_pkg.sv
// rca_pkg: constants shared by the serial add/sub unit, the ripple-carry
// adder and their benches.
//   RCA_WIDTH  default operand width
//   state_t    FSM encodings for the serial unit
//   ADD / SUB  values of the sub control bit
package rca_pkg;

  localparam int RCA_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: request/response bundle for the bit-serial add/sub unit.
//   start, sub, x, y, c_in   request  (controller -> unit)
//   busy, done, s, c_out, ovf response (unit -> controller)
// Modports: master = controller side, slave = unit side.
interface serial_addsub_if #(parameter int WIDTH = rca_pkg::RCA_WIDTH);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, x, y, c_in,
    input  busy, done, s, c_out, ovf
  );

  modport slave (
    input  start, sub, x, y, c_in,
    output busy, done, s, c_out, ovf
  );

endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   a, b, ci  addend bits and carry-in
//   s, co     sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, one full-adder cell and a carry
// flop, one operand bit per clock, LSB first. WIDTH RUN cycles per op, then
// a one-cycle DONE pulse with the result.
//   clk, rst   clock, synchronous active-high reset
//   bus.start  accept request when IDLE or DONE (x, y, sub, c_in captured)
//   bus.busy   high during RUN
//   bus.done   one-cycle pulse when s/c_out/ovf are newly valid
//   bus.s      result, held until the next completion
//   bus.c_out  carry-out (add) or borrow-out (sub)
//   bus.ovf    signed two's-complement overflow
module serial_addsub
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xr, yr;
  logic             subr;
  logic             cy;
  logic [WIDTH-2:0] acc;       // result bits collected so far, MSB-aligned
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] s_q;
  logic             c_q, ovf_q;
  logic             accept, last;
  logic             fa_b, fa_s, fa_co;

  // Subtract is x + ~y + ~borrow, so invert b per bit and the initial carry.
  assign fa_b  = yr[0] ^ subr;
  assign last  = (cnt == CNT_LAST);
  assign acc_n = {fa_s, acc};

  full_adder u_fa (
    .a  (xr[0]),
    .b  (fa_b),
    .ci (cy),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) begin
        state_d = ST_RUN;
        accept  = 1'b1;
      end
      ST_RUN:  if (last) state_d = ST_DONE;
      ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          accept  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      xr    <= '0;
      yr    <= '0;
      subr  <= 1'b0;
      cy    <= 1'b0;
      acc   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        xr   <= bus.x;
        yr   <= bus.y;
        subr <= bus.sub;
        cy   <= bus.sub ? ~bus.c_in : bus.c_in;
        cnt  <= '0;
      end else if (state == ST_RUN) begin
        xr  <= xr >> 1;
        yr  <= yr >> 1;
        cy  <= fa_co;
        acc <= acc_n[WIDTH-1:1];
        if (last) begin
          // Outputs change only here, so they hold the old result during RUN.
          s_q   <= acc_n;
          c_q   <= (subr == SUB) ? ~fa_co : fa_co;
          ovf_q <= cy ^ fa_co;   // carry into MSB vs carry out of MSB
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy  = (state == ST_RUN);
  assign bus.done  = (state == ST_DONE);
  assign bus.s     = s_q;
  assign bus.c_out = c_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and exhaustive checks of serial_addsub, WIDTH=4.
module tb_serial_addsub;
  import rca_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // From the first negedge after an accept edge, count busy cycles and find
  // the cycle index (1-based) in which done is seen. lat=0 means no done.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] ya,
                       input logic ci, input logic sb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xa;
    bus.y     = ya;
    bus.c_in  = ci;
    bus.sub   = sb;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b1; bus.x = 4'hF; bus.y = 4'hF; bus.c_in = 1'b1; bus.sub = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.busy, bus.done, bus.s, bus.c_out, bus.ovf} !== 8'b0) begin
        fails++;
        $display("FAIL reset[%0d]: busy=%b done=%b s=%b c=%b ovf=%b, want all 0",
                 i, bus.busy, bus.done, bus.s, bus.c_out, bus.ovf);
      end
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_accept: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_add;
    logic [W-1:0] xv [3] = '{4'b0011, 4'b1111, 4'b0111};
    logic [W-1:0] yv [3] = '{4'b0011, 4'b1111, 4'b0001};
    logic [W-1:0] se [3] = '{4'b0110, 4'b1110, 4'b1000};
    logic         ce [3] = '{1'b0, 1'b1, 1'b0};
    logic         oe [3] = '{1'b0, 1'b0, 1'b1};
    int lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      issue(xv[i], yv[i], 1'b0, ADD);
      wait_done(lat, bcnt);
      tests++;
      if (lat !== 5 || bcnt !== 4) begin
        fails++;
        $display("FAIL add_timing[%0d]: done_cycle=%0d busy_cycles=%0d, want 5 4", i, lat, bcnt);
      end
      tests++;
      if ({bus.s, bus.c_out, bus.ovf} !== {se[i], ce[i], oe[i]}) begin
        fails++;
        $display("FAIL add[%0d]: s=%b c=%b ovf=%b, want s=%b c=%b ovf=%b",
                 i, bus.s, bus.c_out, bus.ovf, se[i], ce[i], oe[i]);
      end
    end
  endtask

  task automatic test_sub;
    logic [W-1:0] xv [4] = '{4'b0110, 4'b0100, 4'b1000, 4'b0101};
    logic [W-1:0] yv [4] = '{4'b0100, 4'b0110, 4'b0001, 4'b0101};
    logic         ci [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] se [4] = '{4'b0010, 4'b1110, 4'b0111, 4'b1111};
    logic         ce [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic         oe [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      issue(xv[i], yv[i], ci[i], SUB);
      wait_done(lat, bcnt);
      tests++;
      if (lat !== 5 || {bus.s, bus.c_out, bus.ovf} !== {se[i], ce[i], oe[i]}) begin
        fails++;
        $display("FAIL sub[%0d]: done_cycle=%0d s=%b c=%b ovf=%b, want 5 s=%b c=%b ovf=%b",
                 i, lat, bus.s, bus.c_out, bus.ovf, se[i], ce[i], oe[i]);
      end
    end
  endtask

  task automatic test_start_during_run;
    int lat, bcnt;
    logic held_ok;
    // Previous result is 0101-0101-1 = 1111.
    issue(4'b0010, 4'b0011, 1'b0, ADD);
    // First RUN cycle: present a different request; it must be ignored.
    bus.start = 1'b1; bus.x = 4'b1111; bus.y = 4'b1111; bus.sub = SUB; bus.c_in = 1'b1;
    held_ok = 1'b1;
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.busy) begin
        bcnt++;
        if (bus.s !== 4'b1111) held_ok = 1'b0;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    tests++;
    if (!held_ok) begin
      fails++;
      $display("FAIL run_hold: s changed during RUN, want 1111 throughout");
    end
    tests++;
    if (lat !== 5 || bcnt !== 4 || {bus.s, bus.c_out, bus.ovf} !== {4'b0101, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL start_in_run: done_cycle=%0d busy=%0d s=%b c=%b ovf=%b, want 5 4 s=0101 c=0 ovf=0",
               lat, bcnt, bus.s, bus.c_out, bus.ovf);
    end
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL start_in_run_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, bcnt;
    logic saw_done;
    issue(4'b0111, 4'b0001, 1'b0, ADD);
    @(negedge clk);            // second RUN cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({bus.busy, bus.done, bus.s, bus.c_out, bus.ovf} !== 8'b0) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b done=%b s=%b c=%b ovf=%b, want all 0",
               bus.busy, bus.done, bus.s, bus.c_out, bus.ovf);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.done || bus.busy) saw_done = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL reset_abort: busy/done seen after mid-run reset, want none");
    end
    issue(4'b1001, 4'b0011, 1'b1, ADD);
    wait_done(lat, bcnt);
    tests++;
    if (lat !== 5 || {bus.s, bus.c_out, bus.ovf} !== {4'b1101, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL after_reset_op: done_cycle=%0d s=%b c=%b ovf=%b, want 5 s=1101 c=0 ovf=0",
               lat, bus.s, bus.c_out, bus.ovf);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    issue(4'b0011, 4'b0011, 1'b0, ADD);
    wait_done(lat, bcnt);
    tests++;
    if (lat !== 5 || bus.s !== 4'b0110) begin
      fails++;
      $display("FAIL b2b_first: done_cycle=%0d s=%b, want 5 s=0110", lat, bus.s);
    end
    // Request during the DONE cycle.
    bus.start = 1'b1; bus.x = 4'b0100; bus.y = 4'b0110; bus.c_in = 1'b0; bus.sub = SUB;
    @(negedge clk);
    bus.start = 1'b0;
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_handover: done=%b busy=%b, want 0 1", bus.done, bus.busy);
    end
    wait_done(lat, bcnt);
    tests++;
    if (lat !== 5 || bcnt !== 4 || {bus.s, bus.c_out, bus.ovf} !== {4'b1110, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL b2b_second: done_cycle=%0d busy=%0d s=%b c=%b ovf=%b, want 5 4 s=1110 c=1 ovf=0",
               lat, bcnt, bus.s, bus.c_out, bus.ovf);
    end
  endtask

  task automatic test_exhaustive;
    int lat, bcnt;
    int sx, sy, r, ur;
    logic [W-1:0] es;
    logic ec, eo;
    for (int op = 0; op < 1024; op++) begin
      logic [W-1:0] xa, ya;
      logic ci, sb;
      xa = op[3:0];
      ya = op[7:4];
      ci = op[8];
      sb = op[9];
      sx = (xa >= 8) ? int'(xa) - 16 : int'(xa);
      sy = (ya >= 8) ? int'(ya) - 16 : int'(ya);
      if (sb == ADD) begin
        ur = int'(xa) + int'(ya) + int'(ci);
        ec = (ur > 15);
        r  = sx + sy + int'(ci);
      end else begin
        ur = int'(xa) - int'(ya) - int'(ci);
        ec = (ur < 0);
        r  = sx - sy - int'(ci);
      end
      es = ur[3:0];
      eo = (r > 7) || (r < -8);
      issue(xa, ya, ci, sb);
      wait_done(lat, bcnt);
      tests++;
      if (lat !== 5 || {bus.s, bus.c_out, bus.ovf} !== {es, ec, eo}) begin
        fails++;
        $display("FAIL exh x=%b y=%b ci=%b sub=%b: done_cycle=%0d s=%b c=%b ovf=%b, want 5 s=%b c=%b ovf=%b",
                 xa, ya, ci, sb, lat, bus.s, bus.c_out, bus.ovf, es, ec, eo);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
